// File: rtl/led_debug_pkg.sv
// Shared helpers and state encoding for the LED debug multiplexer.
package led_debug_pkg;

  // Ceiling log2, never below 1 so every counter gets at least one bit.
  function automatic int clog2(input int value);
    int bits;
    int rest;
    bits = 0;
    rest = value - 1;
    while (rest > 0) begin
      bits++;
      rest = rest >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  // All-ones LED drive; consumers slice it down to their LED count.
  localparam logic [7:0] LED_OFF = 8'hFF;

endpackage

// File: rtl/led_debug_mux_seq_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; strobes once per newly stable value.
module debounce_sync
  import led_debug_pkg::*;
#(
  parameter int W      = 4,
  parameter int STABLE = 1000000,
  parameter bit INVERT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] value_o,
  output logic         accept_o
);

  localparam int CW = clog2(STABLE);
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE - 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE - 1);

  logic [W-1:0]  s1_q, s2_q, prev_q;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    vld_q;
  logic          same;

  // vld_q masks comparisons that would still involve reset contents of the pipeline.
  assign cand     = INVERT ? ~s2_q : s2_q;
  assign same     = vld_q[2] && (cand == prev_q);
  assign accept_o = same && (cnt_q == CNT_HIT);
  assign value_o  = cand;

  always_comb begin
    cnt_d = cnt_q;
    if (!same)                cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= cand;
      cnt_q  <= cnt_d;
      vld_q  <= {vld_q[1:0], 1'b1};
    end
  end

endmodule

// File: rtl/led_debug_mux_seq.sv
// Debug LED multiplexer: manual DIP selection or auto-scan, with freeze and change strobe.
//   state     | meaning
//   ST_MANUAL | CHANNEL follows the debounced DIP selector
//   ST_SCAN   | CHANNEL steps through all inputs, dwelling C_SCAN_CYCLES each
module led_debug_mux_seq
  import led_debug_pkg::*;
#(
  parameter int C_NUM_INPUTS      = 16,
  parameter int C_DATA_WIDTH      = 4,
  parameter int C_SEL_WIDTH       = 4,
  parameter int C_DEBOUNCE_CYCLES = 1000000,
  parameter int C_SCAN_CYCLES     = 50000000
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0] in_bus_i,
  input  logic [C_SEL_WIDTH-1:0]               selector_i,
  input  logic                                 scan_en_i,
  input  logic                                 freeze_i,
  output logic [C_DATA_WIDTH-1:0]              led_out_o,
  output logic [C_SEL_WIDTH-1:0]               channel_o,
  output logic                                 chan_change_o
);

  localparam int SW      = C_SEL_WIDTH;
  localparam int DWELL_W = clog2(C_SCAN_CYCLES);
  localparam logic [SW-1:0]           LAST_IDX   = SW'(C_NUM_INPUTS - 1);
  localparam logic [DWELL_W-1:0]      DWELL_LAST = DWELL_W'(C_SCAN_CYCLES - 1);
  localparam logic [C_DATA_WIDTH-1:0] LED_BLANK  = LED_OFF[C_DATA_WIDTH-1:0];

  logic [SW-1:0]           sel_val, man_idx_q, man_idx_d;
  logic                    sel_stb;
  logic [1:0]              scan_sync_q, frz_sync_q;
  logic                    scan_s, frz_s;
  state_e                  state_q, state_d;
  logic [SW-1:0]           scan_idx_q, scan_idx_d, chan_q, chan_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    pend_q, pend_d, chg_q;
  logic [C_DATA_WIDTH-1:0] led_q, led_d;

  debounce_sync #(
    .W      (SW),
    .STABLE (C_DEBOUNCE_CYCLES),
    .INVERT (1'b1)
  ) u_sel_db (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .async_i  (selector_i),
    .value_o  (sel_val),
    .accept_o (sel_stb)
  );

  assign scan_s = scan_sync_q[1];
  assign frz_s  = frz_sync_q[1];

  always_comb begin
    man_idx_d = man_idx_q;
    if (sel_stb) man_idx_d = (C_NUM_INPUTS == 1) ? '0 : sel_val;
  end

  // A scan entry while frozen is remembered in pend and loaded on the first unfrozen cycle.
  always_comb begin
    state_d    = scan_s ? ST_SCAN : ST_MANUAL;
    scan_idx_d = scan_idx_q;
    dwell_d    = dwell_q;
    pend_d     = pend_q;
    if (state_d == ST_SCAN) begin
      if (state_q == ST_MANUAL) begin
        pend_d = frz_s;
        if (!frz_s) begin
          scan_idx_d = chan_q;
          dwell_d    = '0;
        end
      end else if (!frz_s) begin
        if (pend_q) begin
          scan_idx_d = chan_q;
          dwell_d    = '0;
          pend_d     = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d    = '0;
          scan_idx_d = (scan_idx_q >= LAST_IDX) ? '0 : scan_idx_q + SW'(1);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
    end
  end

  always_comb begin
    chan_d = chan_q;
    if (!frz_s) chan_d = (state_d == ST_SCAN) ? scan_idx_d : man_idx_q;
    led_d = led_q;
    if (!frz_s) begin
      led_d = LED_BLANK;
      for (int k = 0; k < C_NUM_INPUTS; k++) begin
        if (chan_d == SW'(k)) led_d = ~in_bus_i[k*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_sync_q <= '0;
      frz_sync_q  <= '0;
      man_idx_q   <= '0;
      state_q     <= ST_MANUAL;
      scan_idx_q  <= '0;
      dwell_q     <= '0;
      pend_q      <= 1'b0;
      chan_q      <= '0;
      led_q       <= LED_BLANK;
      chg_q       <= 1'b0;
    end else begin
      scan_sync_q <= {scan_sync_q[0], scan_en_i};
      frz_sync_q  <= {frz_sync_q[0], freeze_i};
      man_idx_q   <= man_idx_d;
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      dwell_q     <= dwell_d;
      pend_q      <= pend_d;
      chan_q      <= chan_d;
      led_q       <= led_d;
      chg_q       <= (chan_d != chan_q);
    end
  end

  assign led_out_o     = led_q;
  assign channel_o     = chan_q;
  assign chan_change_o = chg_q;

endmodule
